// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs
// Brief    : Shared P5 core definitions: next-PC opcodes, reset PC, nop word.
// Revision : 1.0
// ============================================================================
package cpu_defs;

    typedef enum logic [3:0] {
        NPC_PC4    = 4'd0,
        NPC_BRANCH = 4'd1,
        NPC_J      = 4'd2,
        NPC_JR     = 4'd3
    } npc_op_e;

    localparam logic [31:0] PC_INIT = 32'h0000_3000;
    localparam logic [31:0] NOP     = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/npc_unit.sv
`default_nettype none
// ============================================================================
// Module   : npc_unit
// Brief    : Combinational next-PC select from the D-stage control inputs.
// Revision : 1.0
// ============================================================================
module npc_unit
    import cpu_defs::*;
(
    input  logic [31:0] pcF,
    input  logic [31:0] pcD,
    input  logic [3:0]  nPcOp,
    input  logic        cmpRes,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rsData,
    output logic [31:0] npc
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_target;

    assign w_pc4       = pcF + 32'd4;
    // Branch offsets are relative to the delay slot, i.e. pcD + 4.
    assign w_br_target = pcD + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = w_pc4;
        case (nPcOp)
            NPC_BRANCH: npc = cmpRes ? w_br_target : w_pc4;
            NPC_J:      npc = {pcD[31:28], imm26, 2'b00};
            NPC_JR:     npc = rsData;
            default:    npc = w_pc4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : P5 fetch stage: PC register, ROM window check and F/D register.
// Revision : 1.0
// ============================================================================
module fetch_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_INIT  = cpu_defs::PC_INIT,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [3:0]  nPcOp,
    input  logic        cmpRes,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rsData,
    output logic [31:0] pcF,
    input  logic [31:0] instrF,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc8D
);

    localparam logic [32:0] c_IM_BYTES = 33'(IM_WORDS) * 33'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] w_npc;
    logic [31:0] w_off;
    logic        w_fetch_ok;

    npc_unit u_npc (
        .pcF    (pc_q),
        .pcD    (pcd_q),
        .nPcOp  (nPcOp),
        .cmpRes (cmpRes),
        .imm16  (imm16),
        .imm26  (imm26),
        .rsData (rsData),
        .npc    (w_npc)
    );

    // Offset compared in 33 bits so a window ending at 2^32 cannot overflow.
    assign w_off      = pc_q - IM_BASE;
    assign w_fetch_ok = (pc_q >= IM_BASE) && ({1'b0, w_off} < c_IM_BYTES)
                        && (pc_q[1:0] == 2'b00);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        if (!stall) begin
            pc_d    = w_npc;
            instr_d = w_fetch_ok ? instrF : NOP;
            pcd_d   = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_INIT;
            instr_q <= NOP;
            pcd_q   <= PC_INIT;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
        end
    end

    assign pcF    = pc_q;
    assign instrD = instr_q;
    assign pcD    = pcd_q;
    assign pc8D   = pcd_q + 32'd8;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage (vector table + random model).
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [3:0]  nPcOp = 4'd0;
    logic        cmpRes = 1'b0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] rsData = 32'd0;
    logic [31:0] pcF, instrF, instrD, pcD, pc8D;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .nPcOp  (nPcOp),
        .cmpRes (cmpRes),
        .imm16  (imm16),
        .imm26  (imm26),
        .rsData (rsData),
        .pcF    (pcF),
        .instrF (instrF),
        .instrD (instrD),
        .pcD    (pcD),
        .pc8D   (pc8D)
    );

    always #5 clk = ~clk;

    // ROM content: a distinct non-zero word for every address.
    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return {~pc[15:0], pc[15:0]};
    endfunction

    assign instrF = rom_word(pcF);

    // What the stage should latch: ROM word inside 0x3000..0x6FFF if aligned, else nop.
    function automatic logic [31:0] fetch_exp(input logic [31:0] pc);
        if (pc >= 32'h3000 && pc < 32'h7000 && pc % 4 == 0) return rom_word(pc);
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] e_pcF,
                           input logic [31:0] e_pcD, input logic [31:0] e_instrD);
        chk({nm, ".pcF"},   pcF,    e_pcF);
        chk({nm, ".pcD"},   pcD,    e_pcD);
        chk({nm, ".instrD"}, instrD, e_instrD);
        chk({nm, ".pc8D"},  pc8D,   e_pcD + 32'd8);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic c,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        stall = s; nPcOp = op; cmpRes = c; imm16 = i16; imm26 = i26; rsData = rs;
    endtask

    typedef struct {
        logic        s;
        logic [3:0]  op;
        logic        c;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic [31:0] e_pcF;
        logic [31:0] e_pcD;
        logic [31:0] e_instrD;
    } vec_t;

    vec_t vt[16];

    // Behavioural reference for the random phase.
    function automatic logic [31:0] model_npc(input logic [31:0] pf, input logic [31:0] pd,
            input logic [3:0] op, input logic c, input logic [15:0] i16,
            input logic [25:0] i26, input logic [31:0] rs);
        int signed off;
        off = int'($signed(i16)) * 4;
        if (op == 4'd1 && c) return pd + 32'd4 + 32'(off);
        if (op == 4'd2)      return (pd & 32'hF000_0000) | (32'(i26) * 4);
        if (op == 4'd3)      return rs;
        return pf + 32'd4;
    endfunction

    initial begin
        logic [31:0] m_pcF, m_pcD, m_instrD, m_npc;

        vt[0]  = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h3004, 32'h3000, rom_word(32'h3000)};
        vt[1]  = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h3008, 32'h3004, rom_word(32'h3004)};
        vt[2]  = '{0, 4'd1, 1, 16'hFFFF, 26'h0, 32'h0, 32'h3004, 32'h3008, rom_word(32'h3008)};
        vt[3]  = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h3008, 32'h3004, rom_word(32'h3004)};
        vt[4]  = '{0, 4'd1, 0, 16'hFFFF, 26'h0, 32'h0, 32'h300C, 32'h3008, rom_word(32'h3008)};
        vt[5]  = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h3010, 32'h300C, rom_word(32'h300C)};
        vt[6]  = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h3014, 32'h3010, rom_word(32'h3010)};
        vt[7]  = '{0, 4'd2, 0, 16'h0000, 26'hC40, 32'h0, 32'h3100, 32'h3014, rom_word(32'h3014)};
        vt[8]  = '{0, 4'd3, 0, 16'h0000, 26'h0, 32'h3018, 32'h3018, 32'h3100, rom_word(32'h3100)};
        vt[9]  = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h301C, 32'h3018, rom_word(32'h3018)};
        vt[10] = '{0, 4'd0, 0, 16'h0000, 26'h0, 32'h0, 32'h3020, 32'h301C, rom_word(32'h301C)};
        vt[11] = '{1, 4'd1, 1, 16'h0010, 26'h0, 32'h0, 32'h3020, 32'h301C, rom_word(32'h301C)};
        vt[12] = '{1, 4'd1, 0, 16'h0010, 26'h0, 32'h0, 32'h3020, 32'h301C, rom_word(32'h301C)};
        vt[13] = '{1, 4'd1, 1, 16'h0010, 26'h0, 32'h0, 32'h3020, 32'h301C, rom_word(32'h301C)};
        vt[14] = '{0, 4'd1, 1, 16'h0010, 26'h0, 32'h0, 32'h3060, 32'h3020, rom_word(32'h3020)};
        vt[15] = '{0, 4'd9, 1, 16'h0010, 26'h0, 32'h0, 32'h3064, 32'h3060, rom_word(32'h3060)};

        #12;
        chk_all("reset_state", 32'h3000, 32'h3000, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].s, vt[i].op, vt[i].c, vt[i].i16, vt[i].i26, vt[i].rs);
            step();
            chk_all($sformatf("vec%0d", i), vt[i].e_pcF, vt[i].e_pcD, vt[i].e_instrD);
        end

        // Window boundaries, misalignment and 32-bit wrap.
        drive(0, 4'd3, 0, 16'h0, 26'h0, 32'h6FFC); step();
        chk_all("jr_6ffc", 32'h6FFC, 32'h3064, rom_word(32'h3064));
        drive(0, 4'd0, 0, 16'h0, 26'h0, 32'h0); step();
        chk_all("last_word", 32'h7000, 32'h6FFC, rom_word(32'h6FFC));
        step();
        chk_all("out_window", 32'h7004, 32'h7000, 32'h0);
        drive(0, 4'd3, 0, 16'h0, 26'h0, 32'h2FFC); step();
        chk_all("jr_2ffc", 32'h2FFC, 32'h7004, 32'h0);
        drive(0, 4'd3, 0, 16'h0, 26'h0, 32'h3002); step();
        chk_all("below_window", 32'h3002, 32'h2FFC, 32'h0);
        drive(0, 4'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC); step();
        chk_all("misaligned", 32'hFFFF_FFFC, 32'h3002, 32'h0);
        drive(0, 4'd0, 0, 16'h0, 26'h0, 32'h0); step();
        chk_all("wrap_pc4", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0);

        // Asynchronous reset between edges, during a stall, held across an edge.
        drive(1, 4'd2, 0, 16'h0, 26'h3FF_FFFF, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 32'h3000, 32'h3000, 32'h0);
        step();
        chk_all("reset_hold", 32'h3000, 32'h3000, 32'h0);
        reset = 1'b0;

        m_pcF = 32'h3000; m_pcD = 32'h3000; m_instrD = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? $urandom()
                 : (32'h3000 + 32'($urandom_range(0, 4095)) * 4);
            drive(($urandom_range(0, 4) == 0), 4'($urandom_range(0, 5)),
                  1'($urandom()), 16'($urandom()), 26'($urandom_range(0, 32'h1FFF)), rs);
            m_npc = model_npc(m_pcF, m_pcD, nPcOp, cmpRes, imm16, imm26, rsData);
            step();
            if (!stall) begin
                m_instrD = fetch_exp(m_pcF);
                m_pcD    = m_pcF;
                m_pcF    = m_npc;
            end
            chk_all($sformatf("rand%0d", n), m_pcF, m_pcD, m_instrD);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
